// File: rtl/rr_mux_arbiter.sv
// Round-robin owner arbiter for the shared N:1 bit mux.
// Owners keep the mux while they request. An optional hold limit forces
// rotation. The selected data bit is registered onto y.

// Per-requester lane: flags a request at or above the rotation base.
// The top picks from these first and wraps to the raw request vector.
module rr_mux_lane #(
  parameter int N    = 16,
  parameter int SELW = 4,
  parameter int IDX  = 0
) (
  input  logic            req,
  input  logic [SELW-1:0] base,
  output logic            hi
);
  localparam logic [SELW-1:0] IDX_W = SELW'(IDX);

  // Eligible in the upper (non-wrapped) half of the scan.
  assign hi = req & (IDX_W >= base);
endmodule

module rr_mux_arbiter #(
  parameter int N        = 16,
  parameter int SELW     = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    in,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] sel,
  output logic            valid,
  output logic            y
);
  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_W = HW'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nx;
  logic [SELW-1:0] ptr, ptr_nx, sel_nx, base, win;
  logic [HW-1:0]   hcnt, hcnt_nx;
  logic [N-1:0]    hi, gnt_nx;
  logic            rel, y_nx;

  // The current owner gives up the mux: it stopped requesting or used its tenure.
  assign rel = !req[sel] || ((MAX_HOLD != 0) && (hcnt == HOLD_W));

  // On release, the scan starts just past the owner. This is the pointer value
  // being committed this edge, so the handover needs no idle bubble.
  assign base = (state == GRANT && rel) ? SELW'(sel + 1'b1) : ptr;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      rr_mux_lane #(.N(N), .SELW(SELW), .IDX(gi)) u_lane (
        .req  (req[gi]),
        .base (base),
        .hi   (hi[gi])
      );
    end
  endgenerate

  // Lowest set index of hi[] if any, else lowest set index of req (wrap).
  always_comb begin
    win = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) win = SELW'(i);
    end
    if (|hi) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (hi[i]) win = SELW'(i);
      end
    end
  end

  // Next state: grant from idle, hold, or release and re-arbitrate in one edge.
  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    ptr_nx   = ptr;
    hcnt_nx  = hcnt;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nx = GRANT;
          sel_nx   = win;
          hcnt_nx  = HW'(1);
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_nx = base;
          if (|req) begin
            sel_nx  = win;
            hcnt_nx = HW'(1);
          end else begin
            state_nx = IDLE;
          end
        end else if (hcnt != '1) begin
          hcnt_nx = hcnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    gnt_nx = (state_nx == GRANT) ? ({{(N-1){1'b0}}, 1'b1} << sel_nx) : '0;
    y_nx   = (state_nx == GRANT) ? in[sel_nx] : 1'b0;
  end

  // State and registered outputs. Reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      hcnt  <= '0;
      sel   <= '0;
      gnt   <= '0;
      valid <= 1'b0;
      y     <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      hcnt  <= hcnt_nx;
      sel   <= sel_nx;
      gnt   <= gnt_nx;
      valid <= (state_nx == GRANT);
      y     <= y_nx;
    end
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter. Three instances with hold limits 2, 3 and 0 share
// the same stimulus. Each instance is checked against a tenure/pointer model.
module tb_rr_mux_arbiter;
  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req, in;
  logic [N-1:0]  gnt_o   [3];
  logic [3:0]    sel_o   [3];
  logic          valid_o [3];
  logic          y_o     [3];

  int lim [3] = '{2, 3, 0};

  // Model state per instance.
  bit own [3];
  int who [3];
  int ten [3];
  int ptr [3];
  bit yex [3];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.N(N), .SELW(4), .MAX_HOLD(2)) u_h2 (
    .clk(clk), .rst_n(rst_n), .req(req), .in(in),
    .gnt(gnt_o[0]), .sel(sel_o[0]), .valid(valid_o[0]), .y(y_o[0]));
  rr_mux_arbiter #(.N(N), .SELW(4), .MAX_HOLD(3)) u_h3 (
    .clk(clk), .rst_n(rst_n), .req(req), .in(in),
    .gnt(gnt_o[1]), .sel(sel_o[1]), .valid(valid_o[1]), .y(y_o[1]));
  rr_mux_arbiter #(.N(N), .SELW(4), .MAX_HOLD(0)) u_h0 (
    .clk(clk), .rst_n(rst_n), .req(req), .in(in),
    .gnt(gnt_o[2]), .sel(sel_o[2]), .valid(valid_o[2]), .y(y_o[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
  endtask

  // First requester at or after base, wrapping around.
  function automatic int first_from(input logic [N-1:0] r, input int base);
    for (int d = 0; d < N; d++)
      if (r[(base + d) % N]) return (base + d) % N;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      own[k] = 0; who[k] = 0; ten[k] = 0; ptr[k] = 0; yex[k] = 0;
    end
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] d);
    for (int k = 0; k < 3; k++) begin
      if (!own[k]) begin
        if (r != 0) begin
          own[k] = 1; who[k] = first_from(r, ptr[k]); ten[k] = 1;
        end
      end else if (!r[who[k]] || (lim[k] != 0 && ten[k] == lim[k])) begin
        ptr[k] = (who[k] + 1) % N;
        if (r != 0) begin
          who[k] = first_from(r, ptr[k]); ten[k] = 1;
        end else begin
          own[k] = 0;
        end
      end else begin
        ten[k]++;
      end
      yex[k] = own[k] ? d[who[k]] : 1'b0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      logic [N-1:0] g;
      g = own[k] ? (N'(1) << who[k]) : '0;
      chk($sformatf("gnt[h%0d]", lim[k]), 32'(gnt_o[k]), 32'(g));
      chk($sformatf("valid[h%0d]", lim[k]), 32'(valid_o[k]), 32'(own[k]));
      chk($sformatf("y[h%0d]", lim[k]), 32'(y_o[k]), 32'(yex[k]));
      if (own[k]) chk($sformatf("sel[h%0d]", lim[k]), 32'(sel_o[k]), 32'(who[k]));
    end
    if (own[0]) chk("hcnt[h2]", 32'(u_h2.hcnt), 32'(ten[0]));
  endtask

  // Drive inputs for one edge, advance the model, and sample 1ns later.
  task automatic tick(input logic [N-1:0] r, input logic [N-1:0] d);
    req = r; in = d;
    @(posedge clk);
    model_step(r, d);
    #1 check_all();
  endtask

  // Pulse reset between edges and check that outputs drop immediately.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_gnt[h%0d]", lim[k]), 32'(gnt_o[k]), 32'h0);
      chk($sformatf("rst_valid[h%0d]", lim[k]), 32'(valid_o[k]), 32'h0);
      chk($sformatf("rst_y[h%0d]", lim[k]), 32'(y_o[k]), 32'h0);
    end
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int exp_rr [6];
    int exp_h3 [7];
    int exp_hc [6];
    int exp_y  [3];
    exp_rr = '{0, 0, 15, 15, 0, 0};
    exp_h3 = '{4, 4, 4, 5, 5, 5, 4};
    exp_hc = '{1, 2, 1, 2, 1, 2};
    exp_y  = '{1, 0, 1};

    rst_n = 1'b0; req = '0; in = '0;
    model_reset();
    #1 check_all();
    #12 rst_n = 1'b1;

    // Single requester: hold for 5 cycles, release one edge after req drops.
    for (int i = 0; i < 5; i++) begin
      tick(16'h0004, 16'h0004);
      chk("single_sel", 32'(sel_o[2]), 32'd2);
      chk("single_y", 32'(y_o[2]), 32'd1);
    end
    tick(16'h0000, 16'h0004);
    chk("single_idle", 32'(valid_o[2]), 32'd0);

    // Two requesters at both ends, hold limit 2: wrap from 15 back to 0.
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      tick(16'h8001, N'($urandom));
      chk("rr_sel", 32'(sel_o[0]), 32'(exp_rr[i]));
      chk("rr_valid", 32'(valid_o[0]), 32'd1);
    end

    // Hold-limit preemption with limit 3; no limit keeps the first owner.
    pulse_reset();
    for (int i = 0; i < 7; i++) begin
      tick(16'h0030, N'($urandom));
      chk("hold3_sel", 32'(sel_o[1]), 32'(exp_h3[i]));
      chk("hold0_sel", 32'(sel_o[2]), 32'd4);
    end

    // Lone requester re-granted back to back with a fresh tenure.
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      tick(16'h0100, N'($urandom));
      chk("lone_sel", 32'(sel_o[0]), 32'd8);
      chk("lone_valid", 32'(valid_o[0]), 32'd1);
      chk("lone_hcnt", 32'(u_h2.hcnt), 32'(exp_hc[i]));
    end

    // Reset mid-grant, then arbitration restarts from index 0.
    pulse_reset();
    tick(16'h0080, 16'h0080);
    tick(16'h0080, 16'h0080);
    chk("mid_sel", 32'(sel_o[2]), 32'd7);
    pulse_reset();
    tick(16'h0081, 16'h0000);
    chk("post_rst_sel", 32'(sel_o[2]), 32'd0);

    // Data tracking on owner 10; the other input bits are noise.
    pulse_reset();
    tick(16'h0400, N'($urandom) | 16'h0400);
    for (int i = 0; i < 3; i++) begin
      logic [N-1:0] d;
      d = N'($urandom);
      d[10] = 1'(exp_y[i]);
      tick(16'h0400, d);
      chk("data_y", 32'(y_o[2]), 32'(exp_y[i]));
    end

    // Random traffic with mixed densities and occasional resets.
    pulse_reset();
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] r;
      case ($urandom_range(0, 3))
        0: r = N'($urandom) & N'($urandom) & N'($urandom);
        1: r = N'($urandom) & N'($urandom);
        2: r = N'($urandom);
        default: r = (i % 7 < 2) ? '0 : req;
      endcase
      tick(r, N'($urandom));
      if ($urandom_range(0, 99) == 0) pulse_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter and sequencer for the shared 16:1 bit multiplexer datapath. It grants one of N requesters ownership of the mux and drives the one-hot grant and the binary select. It also registers the selected data bit. Owners hold the mux while requesting, with an optional hold limit that forces rotation, so the `n_1mux` path can be shared fairly.

## Interface
- `N`, default 16: number of requesters and mux inputs; must be a power of two, 2..16.
- `SELW`, default 4: select width; must equal log2(N).
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per tenure; 0 = unlimited.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `req`  input  N: per-requester request; level-sensitive.
- `in`  input  N: per-requester data bit; `in[i]` belongs to requester i.
- `gnt`  output  N: one-hot grant, registered; all zero when idle.
- `sel`  output  SELW: binary index of the current owner, registered; drives the mux select.
- `valid`  output  1: high while a grant is active (equals `|gnt`).
- `y`  output  1: registered `in[sel]` while valid; 0 otherwise.

## Operation
- State:
  - FSM with two states, IDLE and GRANT.
  - Rotation pointer `ptr` (SELW bits).
  - Hold counter `hcnt`, width ceil(log2(MAX_HOLD+1)), minimum 1.
- Winner selection:
  - The winner is the first asserted `req` bit scanning from `ptr` upward, wrapping N-1 -> 0.
  - Pure function of `req` and `ptr`; no bias beyond rotation.
- IDLE:
  - `gnt`=0, `valid`=0, `y`=0.
  - If `|req`: load the winner into `sel`/`gnt`, set `valid`=1, set `hcnt`=1, go to GRANT.
- GRANT, each edge, in priority order:
  - Release: triggered when `req[sel]`=0, or when MAX_HOLD!=0 and `hcnt`==MAX_HOLD.
    - On release, `ptr` <= (`sel`+1) mod N.
    - Re-arbitrate the same edge using the new pointer value. If any `req` bit is set, grant the winner directly with no idle bubble and set `hcnt`=1; otherwise go to IDLE.
    - A requester released by the hold limit that is still the only requester is re-granted (new tenure, `hcnt`=1).
  - Otherwise hold: `sel`/`gnt` unchanged, `hcnt` increments (saturating when MAX_HOLD=0).
- Data path: each edge, `y` <= `in[sel_next]` if the next state is GRANT, else 0.
- Reset:
  - All outputs, `ptr`, `hcnt` and the FSM clear immediately on `rst_n` low, independent of `clk`.
  - Reset mid-grant drops `gnt`/`valid`/`y` at once.
  - After `rst_n` rises, the first edge arbitrates from `ptr`=0.

## Timing
- Grant latency: `req` sampled high at edge k gives `gnt`/`sel`/`valid` visible after edge k (0 wait cycles from IDLE).
- Release latency: `req[sel]` sampled low at edge k moves the grant to the next owner, or to idle, after edge k.
- The maximum tenure with MAX_HOLD=M is exactly M cycles of `valid` for that owner before rotation is considered.
- `y` is `in` sampled at the same edge that commits `sel`: one-cycle latency from `in` to `y`.
- Back-to-back handover has no cycle with `gnt`=0.
- `gnt` is always one-hot or zero, and `gnt[sel]`=`valid`.
- Starvation bound: any held `req` is granted within (N-1)·M+1 cycles when M!=0.

## Test plan
- **Single requester, hold, release.**
  - Stimulus: `req`=0x0004, `in`=0x0004 for 5 cycles, then `req`=0.
  - Required response: after the first edge, `gnt`=0x0004, `sel`=2, `valid`=1, `y`=1. `valid` holds for 5 cycles, then all outputs return to 0 one edge after `req` drops.
- **Simultaneous requests, round robin.**
  - Stimulus: `req`=0x8001 held, MAX_HOLD=2.
  - Required response: `sel` sequence 0,0,15,15,0,0 with no idle gap.
  - Also checks the wrap from 15 back to 0.
- **Hold-limit preemption.**
  - Stimulus: MAX_HOLD=3, `req`=0x0030.
  - Required response: `sel`=4 for exactly 3 cycles, then `sel`=5 for 3 cycles, then 4 again.
  - With MAX_HOLD=0, `sel` stays at 4 indefinitely.
- **Lone requester re-grant.**
  - Stimulus: MAX_HOLD=2, `req`=0x0100.
  - Required response: `sel`=8 and `valid`=1 continuously; `hcnt` cycles 1,2,1,2.
- **Reset mid-grant.**
  - Stimulus: drive `rst_n` low between edges while `sel`=7 is granted.
  - Required response: `gnt`=0, `valid`=0, `y`=0 immediately. After `rst_n` releases with `req`=0x0081, the first grant goes to `sel`=0.
- **Data tracking.**
  - Stimulus: owner `sel`=10; toggle `in[10]` 1,0,1; toggle the other `in` bits randomly.
  - Required response: `y` follows 1,0,1 with one-cycle latency, unaffected by the other bits.
